kd_tree_node_loader: RTL and testbench
======================================

# kd_tree_node_loader

Programming-side counterpart of the KD-tree internal nodes. Accepts a stream of (split dimension, median) pairs from the tree-build path and turns them into per-node write strobes plus the packed 22-bit storage word each node latches. Nodes are loaded in breadth-first heap order, root first. It sits between the host/config receiver and the array of internal nodes, and signals when the tree is fully programmed and may start routing patches.

## Interface
Parameters:
- NUM_NODES, 31, internal nodes in the tree (depth-5 complete tree); node k has children 2k+1 and 2k+2
- ADDR_WIDTH, 5, width of node counter; must satisfy 2^ADDR_WIDTH >= NUM_NODES
- STORAGE_WIDTH, 22, node storage word width

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse that begins a load; ignored unless idle
- in_valid  in  1  config word offered
- in_ready  out  1  loader accepts config word
- in_idx  in  3  split dimension, legal 0..4
- in_median  in  11  signed median
- wen  out  NUM_NODES  one-hot node write strobe
- wdata  out  STORAGE_WIDTH  packed node word
- busy  out  1  load in progress
- done  out  1  one-cycle pulse, tree fully written
- err  out  1  sticky, an illegal in_idx (5..7) was accepted during the current load

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE: in_ready=0, busy=0. start=1 -> LOAD; node counter cleared to 0; err cleared.
- LOAD: in_ready=1, busy=1. Handshake = in_valid && in_ready. On each handshake:
  - wdata <= {in_median, 8'b0, in_idx}: bits [21:11] median, [10:3] zero, [2:0] index.
  - wen <= one-hot of the current counter; counter increments.
  - in_idx > 4 sets err. The word is still written and the load is not aborted.
  - A handshake with counter == NUM_NODES-1 -> DONE.
- DONE: in_ready=0, busy=1, done=1 for exactly one cycle -> IDLE.
- start while busy: ignored. in_valid outside LOAD: ignored, nothing consumed.
- wdata holds its last value between writes. wen is all-zero in every cycle without a registered write.
- Never more than one wen bit high. Each node is written exactly once per load.

## Timing
- Reset values: in_ready=0, wen=0, wdata=0, busy=0, done=0, err=0, state IDLE, counter 0.
- start sampled at edge t -> LOAD from t+1; in_ready high in cycle t+1.
- Handshake at edge t -> wen/wdata valid during cycle t+1, one cycle only. Throughput is one node per cycle with in_valid held high.
- Last handshake at edge t -> last wen and done both high in cycle t+1; busy low and IDLE from t+2.
- Full back-to-back load takes NUM_NODES+2 cycles from start to busy falling.
- in_valid gaps during LOAD stall the counter with no wen and no timeout.
- Reset asserted mid-load clears everything asynchronously. A partial tree is not resumed; a new start restarts at node 0.
- start coinciding with done is ignored, because the state is still DONE.

## Structure
- Shared package holds:
  - STORAGE_WIDTH, the field offsets (MEDIAN_LSB=11, IDX_WIDTH=3), and MAX_DIM_IDX=4, shared with the internal node.
  - The loader state enum.
- Sub-module kd_node_wen_decoder: registered-enable binary-to-one-hot decoder (ADDR_WIDTH -> NUM_NODES), reused by leaf-node loading.

## Test plan
- Reset, then start with 31 back-to-back words (idx=k%5, median=k-15) -> wen bit k high in cycle k+2 after start; wdata[21:11]=k-15, wdata[2:0]=k%5; done in the same cycle as wen[30].
- in_valid toggled every other cycle -> wen only on handshake cycles; counter never skips; done after the 31st word.
- Word with in_idx=6 at node 3 -> wen[3] fires with wdata[2:0]=6; err=1 and stays high through done; cleared by the next start.
- start pulsed at mid-load node 10 -> ignored; no counter reset; no extra wen.
- rst_n low at node 12 for one cycle -> all outputs 0 immediately; after a new start, the first wen is wen[0].
- in_median=-1024 and +1023 -> wdata[21:11]=0x400 and 0x3FF; bits [10:3]=0.

Source files
------------

// File: rtl/kd_tree_node_loader_pkg.sv
// Shared definitions for the KD-tree node loader and the internal node storage word.
package kd_tree_node_loader_pkg;

  localparam int unsigned STORAGE_WIDTH = 22;
  localparam int unsigned IDX_WIDTH     = 3;
  localparam int unsigned MEDIAN_WIDTH  = 11;
  localparam int unsigned MEDIAN_LSB    = 11;
  localparam int unsigned PAD_WIDTH     = MEDIAN_LSB - IDX_WIDTH;
  localparam int unsigned MAX_DIM_IDX   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } loader_state_e;

  // Node storage word: median in the top field, split dimension in the bottom field.
  typedef struct packed {
    logic [MEDIAN_WIDTH-1:0] median;
    logic [PAD_WIDTH-1:0]    pad;
    logic [IDX_WIDTH-1:0]    idx;
  } node_word_t;

  function automatic node_word_t pack_node_word(input logic [IDX_WIDTH-1:0]    idx,
                                                input logic [MEDIAN_WIDTH-1:0] median);
    node_word_t w;
    w.median = median;
    w.pad    = '0;
    w.idx    = idx;
    return w;
  endfunction

endpackage

// File: rtl/kd_node_wen_decoder.sv
// Registered binary-to-one-hot write-strobe decoder; all-zero when not enabled.
module kd_node_wen_decoder #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_NODES  = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [NUM_NODES-1:0]  wen
);

  logic [NUM_NODES-1:0] wen_d;
  logic [NUM_NODES-1:0] wen_q;

  always_comb begin
    wen_d = '0;
    for (int unsigned i = 0; i < NUM_NODES; i++) begin
      wen_d[i] = en && (addr == ADDR_WIDTH'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q <= '0;
    end else begin
      wen_q <= wen_d;
    end
  end

  assign wen = wen_q;

endmodule

// File: rtl/kd_tree_node_loader.sv
// Streams (split dimension, median) pairs into the KD-tree internal nodes in heap order.
module kd_tree_node_loader #(
  parameter int unsigned NUM_NODES     = 31,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned STORAGE_WIDTH = kd_tree_node_loader_pkg::STORAGE_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_idx,
  input  logic [10:0]              in_median,
  output logic [NUM_NODES-1:0]     wen,
  output logic [STORAGE_WIDTH-1:0] wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  import kd_tree_node_loader_pkg::loader_state_e;
  import kd_tree_node_loader_pkg::ST_IDLE;
  import kd_tree_node_loader_pkg::ST_LOAD;
  import kd_tree_node_loader_pkg::ST_DONE;
  import kd_tree_node_loader_pkg::MAX_DIM_IDX;
  import kd_tree_node_loader_pkg::pack_node_word;

  loader_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]     cnt_q, cnt_d;
  logic [STORAGE_WIDTH-1:0]  wdata_q, wdata_d;
  logic                      in_ready_q, in_ready_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      hs_c;

  assign hs_c = in_valid && in_ready_q;

  // Next state, node counter and registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (hs_c) begin
          wdata_d = STORAGE_WIDTH'(pack_node_word(in_idx, in_median));
          cnt_d   = cnt_q + ADDR_WIDTH'(1);
          if (in_idx > 3'(MAX_DIM_IDX)) begin
            err_d = 1'b1;
          end
          if (cnt_q == ADDR_WIDTH'(NUM_NODES - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_LOAD);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wdata_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Strobe for the node addressed by the pre-increment counter.
  kd_node_wen_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_NODES  (NUM_NODES)
  ) u_wen_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hs_c),
    .addr  (cnt_q),
    .wen   (wen)
  );

  assign in_ready = in_ready_q;
  assign wdata    = wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_kd_tree_node_loader.sv
// Directed self-checking bench for kd_tree_node_loader.
module tb_kd_tree_node_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid;
  logic [2:0]  in_idx;
  logic [10:0] in_median;
  logic        in_ready, busy, done, err;
  logic [30:0] wen;
  logic [21:0] wdata;

  int errors = 0;
  int checks = 0;

  kd_tree_node_loader #(.NUM_NODES(31), .ADDR_WIDTH(5), .STORAGE_WIDTH(22)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .in_median(in_median), .wen(wen), .wdata(wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [21:0] exp_word(input int idx, input int med);
    return {11'(med), 8'h00, 3'(idx)};
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0; in_valid = 1'b0; start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_idx = '0; in_median = '0;
    #3;
    checks++; if (wen !== 31'd0) begin errors++; $display("FAIL reset_wen: got %h want 0", wen); end
    checks++; if (wdata !== 22'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", wdata); end
    checks++; if ({in_ready, busy, done, err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {in_ready, busy, done, err});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [30:0] ew;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      ew = '0;
      if (c >= 2 && c <= 32) ew[c-2] = 1'b1;
      checks++; if (wen !== ew) begin errors++; $display("FAIL b2b_wen c%0d: got %h want %h", c, wen, ew); end
      checks++; if (done !== (c == 32)) begin errors++; $display("FAIL b2b_done c%0d: got %b want %b", c, done, c == 32); end
      checks++; if (busy !== (c <= 32)) begin errors++; $display("FAIL b2b_busy c%0d: got %b want %b", c, busy, c <= 32); end
      checks++; if (in_ready !== (c <= 31)) begin errors++; $display("FAIL b2b_ready c%0d: got %b want %b", c, in_ready, c <= 31); end
      if (c >= 2 && c <= 32) begin
        checks++;
        if (wdata !== exp_word((c - 2) % 5, c - 2 - 15)) begin
          errors++; $display("FAIL b2b_wdata c%0d: got %h want %h", c, wdata, exp_word((c - 2) % 5, c - 2 - 15));
        end
      end
      in_valid = (c <= 31); in_idx = 3'((c - 1) % 5); in_median = 11'(c - 1 - 15);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_gaps();
    logic [30:0] ew;
    logic [21:0] ewd;
    logic        ed, fin;
    int          k;
    ew = '0; ewd = '0; ed = 1'b0; fin = 1'b0; k = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c < 100 && !fin; c++) begin
      checks++; if (wen !== ew) begin errors++; $display("FAIL gap_wen c%0d: got %h want %h", c, wen, ew); end
      checks++; if (done !== ed) begin errors++; $display("FAIL gap_done c%0d: got %b want %b", c, done, ed); end
      if (ew != 31'd0) begin
        checks++; if (wdata !== ewd) begin errors++; $display("FAIL gap_wdata c%0d: got %h want %h", c, wdata, ewd); end
      end
      if (ed) fin = 1'b1;
      ew = '0; ed = 1'b0;
      if (k < 31 && (c % 2) == 1) begin
        in_valid = 1'b1; in_idx = 3'(k % 5); in_median = 11'(k);
        ew[k] = 1'b1; ewd = exp_word(k % 5, k); ed = (k == 30); k++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL gap_timeout: got done=%b want 1", fin); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_err();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      checks++; if (err !== (c >= 5)) begin errors++; $display("FAIL err_flag c%0d: got %b want %b", c, err, c >= 5); end
      if (c == 5) begin
        checks++; if (wen !== 31'h8) begin errors++; $display("FAIL err_wen3: got %h want 00000008", wen); end
        checks++; if (wdata[2:0] !== 3'd6) begin errors++; $display("FAIL err_idx: got %0d want 6", wdata[2:0]); end
      end
      if (c == 32) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL err_done: got %b want 1", done); end
      end
      in_valid = (c <= 31); in_idx = (c - 1 == 3) ? 3'd6 : 3'd0; in_median = 11'd0;
      tick();
    end
    in_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL err_restart: got busy=%b want 1", busy); end
    pulse_reset();
  endtask

  task automatic test_start_ignored();
    logic [30:0] ew;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      ew = '0;
      if (c >= 2 && c <= 32) ew[c-2] = 1'b1;
      checks++; if (wen !== ew) begin errors++; $display("FAIL sti_wen c%0d: got %h want %h", c, wen, ew); end
      checks++; if (busy !== (c <= 32)) begin errors++; $display("FAIL sti_busy c%0d: got %b want %b", c, busy, c <= 32); end
      start = (c == 11) || (c == 32);
      in_valid = (c <= 31); in_idx = 3'd1; in_median = 11'(c);
      tick();
    end
    start = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sti_ready_after: got %b want 0", in_ready); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      in_valid = 1'b1; in_idx = 3'd3; in_median = 11'(c);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (wen !== 31'h1000) begin errors++; $display("FAIL rst_pre_wen12: got %h want 00001000", wen); end
    rst_n = 1'b0;
    #1;
    checks++; if (wen !== 31'd0 || wdata !== 22'd0) begin
      errors++; $display("FAIL rst_async_data: got wen=%h wdata=%h want 0/0", wen, wdata);
    end
    checks++; if ({in_ready, busy, done, err} !== 4'b0000) begin
      errors++; $display("FAIL rst_async_flags: got %b want 0000", {in_ready, busy, done, err});
    end
    tick();
    rst_n = 1'b1; in_valid = 1'b1; in_idx = 3'd2; in_median = 11'd5;
    tick();
    checks++; if (in_ready !== 1'b0 || wen !== 31'd0) begin
      errors++; $display("FAIL rst_idle_ignore: got ready=%b wen=%h want 0/0", in_ready, wen);
    end
    in_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (wen !== 31'h1) begin errors++; $display("FAIL rst_restart_wen0: got %h want 00000001", wen); end
    checks++; if (wdata !== exp_word(2, 5)) begin errors++; $display("FAIL rst_restart_wdata: got %h want %h", wdata, exp_word(2, 5)); end
    pulse_reset();
  endtask

  task automatic test_median_extremes();
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_idx = 3'd1; in_median = 11'h400;
    tick();
    in_idx = 3'd4; in_median = 11'h3FF;
    checks++; if (wdata[21:11] !== 11'h400) begin errors++; $display("FAIL med_neg: got %h want 400", wdata[21:11]); end
    checks++; if (wdata[10:3] !== 8'h00 || wdata[2:0] !== 3'd1) begin
      errors++; $display("FAIL med_neg_low: got %h want 001", wdata[10:0]);
    end
    tick();
    in_valid = 1'b0;
    checks++; if (wdata[21:11] !== 11'h3FF) begin errors++; $display("FAIL med_pos: got %h want 3ff", wdata[21:11]); end
    checks++; if (wdata[10:3] !== 8'h00 || wdata[2:0] !== 3'd4) begin
      errors++; $display("FAIL med_pos_low: got %h want 004", wdata[10:0]);
    end
    tick();
    checks++; if (wen !== 31'd0 || wdata[21:11] !== 11'h3FF) begin
      errors++; $display("FAIL med_hold: got wen=%h med=%h want 0/3ff", wen, wdata[21:11]);
    end
    pulse_reset();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_err();
    test_start_ignored();
    test_reset_mid();
    test_median_extremes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
